// File: rtl/ps2_pkg.sv
// Shared definitions for the multi-channel PS/2 device transmitter.
// Frame states are numbered so that the data-bit states can be advanced by increment.
package ps2_pkg;

  localparam int PS2_CH_W  = 3;
  localparam int FRAME_LEN = 11;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_D0     = 4'd1,
    ST_D1     = 4'd2,
    ST_D2     = 4'd3,
    ST_D3     = 4'd4,
    ST_D4     = 4'd5,
    ST_D5     = 4'd6,
    ST_D6     = 4'd7,
    ST_D7     = 4'd8,
    ST_PARITY = 4'd9,
    ST_STOP   = 4'd10,
    ST_DONE   = 4'(FRAME_LEN)
  } tx_state_t;

endpackage

// File: rtl/ps2_tx_channel.sv
// One PS/2 device port: byte FIFO, sticky overflow flag and 11-bit frame serializer.
// The head byte is only popped once its frame completes, so an aborted frame resends it.
module ps2_tx_channel
  import ps2_pkg::*;
#(
  parameter int FIFO_BITS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       phase,
  input  logic       inhibit,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       fifo_full,
  output logic       fifo_empty,
  output logic       overflow,
  output logic       busy,
  output logic       ps2_clk_out,
  output logic       ps2_data_out
);

  localparam int DEPTH = 2 ** FIFO_BITS;

  logic [7:0]         mem_r [DEPTH];
  logic [FIFO_BITS:0] wptr_r;
  logic [FIFO_BITS:0] rptr_r;
  logic               overflow_r;
  tx_state_t          state_r;
  logic [7:0]         shift_r;
  logic               parity_r;
  logic               data_r;
  logic               full_s;
  logic               empty_s;
  logic               push_s;
  logic               pop_s;
  logic               in_frame_s;

  assign empty_s    = (wptr_r == rptr_r);
  assign full_s     = (wptr_r[FIFO_BITS] != rptr_r[FIFO_BITS]) &&
                      (wptr_r[FIFO_BITS-1:0] == rptr_r[FIFO_BITS-1:0]);
  assign push_s     = wr_en && !full_s;
  assign pop_s      = tick && (state_r == ST_DONE);
  // The done state is excluded: once there the byte counts as delivered.
  assign in_frame_s = (state_r != ST_IDLE) && (state_r != ST_DONE);

  assign fifo_full    = full_s;
  assign fifo_empty   = empty_s;
  assign overflow     = overflow_r;
  assign busy         = (state_r != ST_IDLE);
  assign ps2_clk_out  = phase | (state_r == ST_IDLE);
  assign ps2_data_out = data_r;

  // FIFO storage write port
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wptr_r[FIFO_BITS-1:0]] <= wr_data;
    end
  end

  // FIFO pointers and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_r     <= '0;
      rptr_r     <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        wptr_r <= wptr_r + (FIFO_BITS + 1)'(1);
      end
      if (pop_s) begin
        rptr_r <= rptr_r + (FIFO_BITS + 1)'(1);
      end
      if (wr_en && full_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Frame serializer: start, 8 data bits LSB first, odd parity, stop, then pop
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      shift_r  <= 8'h00;
      parity_r <= 1'b1;
      data_r   <= 1'b1;
    end else if (inhibit && in_frame_s) begin
      state_r <= ST_IDLE;
      data_r  <= 1'b1;
    end else if (tick) begin
      case (state_r)
        ST_IDLE: begin
          if (!empty_s && !inhibit) begin
            shift_r  <= mem_r[rptr_r[FIFO_BITS-1:0]];
            data_r   <= 1'b0;
            parity_r <= 1'b1;
            state_r  <= ST_D0;
          end
        end
        ST_D0, ST_D1, ST_D2, ST_D3, ST_D4, ST_D5, ST_D6, ST_D7: begin
          data_r   <= shift_r[0];
          shift_r  <= {1'b0, shift_r[7:1]};
          parity_r <= parity_r ^ shift_r[0];
          state_r  <= tx_state_t'(state_r + 4'd1);
        end
        ST_PARITY: begin
          data_r  <= parity_r;
          state_r <= ST_STOP;
        end
        ST_STOP: begin
          data_r  <= 1'b1;
          state_r <= ST_DONE;
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          data_r  <= 1'b1;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/ps2_dev_tx_multi.sv
// N-channel PS/2 device-side transmitter: shared clock divider, write decode, per-channel FIFO+serializer.
// Optional host clock-inhibit sensing is enabled with `define PS2_HOST_INHIBIT_EN.
module ps2_dev_tx_multi
  import ps2_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int FIFO_BITS = 3,
  parameter int PS2DIV    = 100
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                wr_strobe,
  input  logic [PS2_CH_W-1:0] wr_ch,
  input  logic [7:0]          wr_data,
  output logic [CHANNELS-1:0] fifo_full,
  output logic [CHANNELS-1:0] fifo_empty,
  output logic [CHANNELS-1:0] overflow,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] ps2_clk_out,
  output logic [CHANNELS-1:0] ps2_data_out
`ifdef PS2_HOST_INHIBIT_EN
  ,
  input  logic [CHANNELS-1:0] ps2_clk_in
`endif
);

  localparam int DIV_W = (PS2DIV > 0) ? $clog2(PS2DIV + 1) : 1;

  logic [DIV_W-1:0]    div_cnt_r;
  logic                phase_r;
  logic                div_wrap_s;
  logic                tick_s;
  logic [CHANNELS-1:0] inhibit_s;

  assign div_wrap_s = (div_cnt_r == DIV_W'(PS2DIV));
  assign tick_s     = div_wrap_s && !phase_r;

  // Shared PS/2 half-period divider; tick marks the rising phase edge
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      div_cnt_r <= '0;
      phase_r   <= 1'b0;
    end else if (div_wrap_s) begin
      div_cnt_r <= '0;
      phase_r   <= ~phase_r;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

`ifdef PS2_HOST_INHIBIT_EN
  logic [CHANNELS-1:0] clk_in_meta_r;
  logic [CHANNELS-1:0] clk_in_sync_r;

  // Two-flop synchroniser for the host clock sense lines
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_in_meta_r <= {CHANNELS{1'b1}};
      clk_in_sync_r <= {CHANNELS{1'b1}};
    end else begin
      clk_in_meta_r <= ps2_clk_in;
      clk_in_sync_r <= clk_in_meta_r;
    end
  end

  // Host holds the clock low while we are releasing it high
  assign inhibit_s = ~clk_in_sync_r & ps2_clk_out;
`else
  assign inhibit_s = {CHANNELS{1'b0}};
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    ps2_tx_channel #(
      .FIFO_BITS(FIFO_BITS)
    ) u_chan (
      .clk         (clk_sys),
      .reset       (reset),
      .tick        (tick_s),
      .phase       (phase_r),
      .inhibit     (inhibit_s[c]),
      .wr_en       (wr_strobe && (wr_ch == PS2_CH_W'(c))),
      .wr_data     (wr_data),
      .fifo_full   (fifo_full[c]),
      .fifo_empty  (fifo_empty[c]),
      .overflow    (overflow[c]),
      .busy        (busy[c]),
      .ps2_clk_out (ps2_clk_out[c]),
      .ps2_data_out(ps2_data_out[c])
    );
  end

endmodule

// File: tb/tb_ps2_dev_tx_multi.sv
// Self-checking bench for ps2_dev_tx_multi: queue/frame-level model plus directed literal checks.
module tb_ps2_dev_tx_multi;

  localparam int CH    = 2;
  localparam int FB    = 3;
  localparam int DIV   = 4;
  localparam int DEPTH = 2 ** FB;
  localparam int TP    = 2 * (DIV + 1);

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_strobe = 1'b0;
  logic [2:0] wr_ch = 3'd0;
  logic [7:0] wr_data = 8'h00;
  logic [CH-1:0] fifo_full, fifo_empty, overflow, busy, ps2_clk_out, ps2_data_out;
`ifdef PS2_HOST_INHIBIT_EN
  logic [CH-1:0] ps2_clk_in = 2'b11;
`endif

  always #5 clk = ~clk;

  ps2_dev_tx_multi #(.CHANNELS(CH), .FIFO_BITS(FB), .PS2DIV(DIV)) dut (
    .clk_sys     (clk),
    .reset       (reset),
    .wr_strobe   (wr_strobe),
    .wr_ch       (wr_ch),
    .wr_data     (wr_data),
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty),
    .overflow    (overflow),
    .busy        (busy),
    .ps2_clk_out (ps2_clk_out),
    .ps2_data_out(ps2_data_out)
`ifdef PS2_HOST_INHIBIT_EN
    ,
    .ps2_clk_in  (ps2_clk_in)
`endif
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] mq [CH][$];
  logic [7:0] cur [CH];
  int         pos [CH];
  logic [CH-1:0] m_ovf;
  int         k;
  bit         last_tick;
  bit         chk_en = 1'b0;

  // Wire level of frame bit p for byte b: start, LSB-first data, odd parity, stop
  function automatic logic fbit(input logic [7:0] b, input int p);
    if (p == 0) return 1'b0;
    else if (p <= 8) return b[p-1];
    else if (p == 9) return ~^b;
    else return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < CH; c++) begin
        mq[c].delete();
        pos[c] = -1;
      end
      m_ovf = '0;
      k = 0;
      last_tick = 1'b0;
    end else begin
      bit full_b [CH];
      k++;
      last_tick = ((k % TP) == (DIV + 1));
      for (int c = 0; c < CH; c++) full_b[c] = (mq[c].size() == DEPTH);
      if (last_tick) begin
        for (int c = 0; c < CH; c++) begin
          if (pos[c] < 0) begin
            if (mq[c].size() > 0) begin
              cur[c] = mq[c][0];
              pos[c] = 0;
            end
          end else if (pos[c] < 10) begin
            pos[c]++;
          end else begin
            void'(mq[c].pop_front());
            pos[c] = -1;
          end
        end
      end
      if (wr_strobe && (wr_ch < CH)) begin
        if (full_b[wr_ch]) m_ovf[wr_ch] = 1'b1;
        else mq[wr_ch].push_back(wr_data);
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      logic [CH-1:0] e_empty, e_full, e_busy, e_data, e_clk;
      logic ph;
      ph = ((k / (DIV + 1)) % 2) == 1;
      for (int c = 0; c < CH; c++) begin
        e_empty[c] = (mq[c].size() == 0);
        e_full[c]  = (mq[c].size() == DEPTH);
        e_busy[c]  = (pos[c] >= 0);
        e_data[c]  = (pos[c] < 0) ? 1'b1 : fbit(cur[c], pos[c]);
        e_clk[c]   = ph | ~e_busy[c];
      end
      chk("m_empty", 32'(fifo_empty), 32'(e_empty));
      chk("m_full", 32'(fifo_full), 32'(e_full));
      chk("m_ovf", 32'(overflow), 32'(m_ovf));
      chk("m_busy", 32'(busy), 32'(e_busy));
      chk("m_data", 32'(ps2_data_out), 32'(e_data));
      chk("m_clk", 32'(ps2_clk_out), 32'(e_clk));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr(input logic [2:0] ch, input logic [7:0] d);
    wr_strobe = 1'b1;
    wr_ch = ch;
    wr_data = d;
    @(negedge clk);
    wr_strobe = 1'b0;
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!last_tick && n < TP + 2);
    chk("tick_seen", 32'(last_tick), 32'd1);
  endtask

  task automatic wait_start(input int c);
    logic pb;
    int n;
    bit seen;
    pb = busy[c];
    n = 0;
    seen = 1'b0;
    while (!seen && n < 300) begin
      @(negedge clk);
      n++;
      if (busy[c] && !pb) seen = 1'b1;
      pb = busy[c];
    end
    chk($sformatf("start_ch%0d", c), 32'(seen), 32'd1);
  endtask

  task automatic cap_frame(input int c, output logic [10:0] f);
    f = '1;
    wait_start(c);
    f[0] = ps2_data_out[c];
    for (int i = 1; i < 11; i++) begin
      wait_tick();
      f[i] = ps2_data_out[c];
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1);
  end

  initial begin
    logic [10:0] fa, fb;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_clk", 32'(ps2_clk_out), 32'h3);
    chk("rst_data", 32'(ps2_data_out), 32'h3);
    chk("rst_empty", 32'(fifo_empty), 32'h3);
    chk("rst_full", 32'(fifo_full), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    chk_en = 1'b1;

    // single byte 0xF0: 0,0000,1111,parity 1,stop 1
    wait_tick();
    wr(3'd0, 8'hF0);
    cap_frame(0, fa);
    chk("frame_f0", 32'(fa), 32'h7E0);
    wait_tick();
    chk("f0_empty", 32'(fifo_empty[0]), 32'd1);
    chk("f0_idle", 32'(busy[0]), 32'd0);

    // concurrent frames on both channels
    wait_tick();
    wr(3'd1, 8'h01);
    wr(3'd0, 8'h03);
    fork
      cap_frame(0, fa);
      cap_frame(1, fb);
    join
    chk("frame_03", 32'(fa), 32'h606);
    chk("frame_01", 32'(fb), 32'h402);
    chk("par_ch0", 32'(fa[9]), 32'd1);
    chk("par_ch1", 32'(fb[9]), 32'd0);
    wait_tick();
    wait_tick();
    chk("both_idle", 32'(busy), 32'h0);

    // fill, overflow, drain in order
    wait_tick();
    for (int i = 0; i < 8; i++) wr(3'd0, 8'h10 + 8'(i));
    chk("full_after8", 32'(fifo_full[0]), 32'd1);
    chk("no_ovf_yet", 32'(overflow[0]), 32'd0);
    wr(3'd0, 8'hEE);
    chk("ovf_set", 32'(overflow), 32'h1);
    chk("still_full", 32'(fifo_full[0]), 32'd1);
    for (int i = 0; i < 8; i++) begin
      cap_frame(0, fa);
      chk($sformatf("drain_byte%0d", i), 32'(fa[8:1]), 32'(8'h10 + 8'(i)));
      chk($sformatf("drain_frm%0d", i), 32'({fa[10], fa[0]}), 32'h2);
    end
    wait_tick();
    wait_tick();
    chk("drained_empty", 32'(fifo_empty[0]), 32'd1);

    // out-of-range channel writes are ignored
    wr(3'd5, 8'h55);
    wr(3'd2, 8'h66);
    chk("badch_empty", 32'(fifo_empty), 32'h3);
    chk("badch_ovf", 32'(overflow), 32'h1);
    chk("badch_busy", 32'(busy), 32'h0);

    // reset in state 5 of a frame
    wait_tick();
    wr(3'd0, 8'hA5);
    wr(3'd0, 8'h5A);
    wr(3'd1, 8'h33);
    wait_start(0);
    repeat (4) wait_tick();
    chk("pre_rst_busy", 32'(busy[0]), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_clk", 32'(ps2_clk_out), 32'h3);
    chk("midrst_data", 32'(ps2_data_out), 32'h3);
    chk("midrst_empty", 32'(fifo_empty), 32'h3);
    chk("midrst_ovf", 32'(overflow), 32'h0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

`ifdef PS2_HOST_INHIBIT_EN
    // host inhibit in state 4 of 0xAA aborts, then the byte is resent once
    chk_en = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_tick();
    wr(3'd0, 8'hAA);
    wait_start(0);
    repeat (3) wait_tick();
    ps2_clk_in[0] = 1'b0;
    begin
      int n = 0;
      while (busy[0] && n < 30) begin
        @(negedge clk);
        n++;
      end
    end
    chk("inh_abort", 32'(busy[0]), 32'd0);
    chk("inh_data", 32'(ps2_data_out[0]), 32'd1);
    chk("inh_kept", 32'(fifo_empty[0]), 32'd0);
    repeat (30) @(negedge clk);
    chk("inh_hold", 32'(busy[0]), 32'd0);
    ps2_clk_in[0] = 1'b1;
    cap_frame(0, fa);
    chk("frame_aa", 32'(fa), 32'h754);
    wait_tick();
    wait_tick();
    chk("inh_popped", 32'(fifo_empty[0]), 32'd1);
    chk("inh_done", 32'(busy[0]), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
